morse_symbol_shifter: RTL
=========================

// Module: morse_symbol_shifter
// PURPOSE
//  Parametrised successor to the letter shift register in the Morse transmitter.
//  Accepts one variable-length dot/dash pattern per load and presents one symbol
//  at a time to the tone/timing FSM. Each symbol-timer tick advances to the next
//  symbol. Adds a length field, ready/done handshake, selectable bit order and a
//  remaining-symbol count.
// PARAMETERS
//  MAX_LEN    5   max symbols per pattern (5 covers digits)
//  LEN_W      3   width of length/remaining; must hold MAX_LEN
//  MSB_FIRST  0   0: pattern[0] sent first; 1: pattern[MAX_LEN-1] sent first
// PORTS
//  CLOCK_50      in   1        system clock, rising edge
//  reset         in   1        asynchronous, active-high reset
//  load          in   1        accept pattern/length; honoured only when ready=1
//  pattern       in   MAX_LEN  symbol bits, 1=dash, 0=dot
//  length        in   LEN_W    number of valid symbols in pattern
//  enable        in   1        symbol-consumed tick from timing FSM
//  ready         out  1        idle, load will be accepted
//  dash_or_dot   out  1        current symbol (valid when symbol_valid=1)
//  symbol_valid  out  1        a symbol is being presented
//  remaining     out  LEN_W    symbols left, including the current one
//  done          out  1        one-cycle pulse after the last symbol is consumed
// BEHAVIOUR
//  - States: IDLE, SHIFT. Reset forces IDLE immediately:
//    ready=1, symbol_valid=0, dash_or_dot=0, remaining=0, done=0, shift reg=0.
//  - ready=(state==IDLE); symbol_valid=(state==SHIFT).
//  - dash_or_dot = shreg[0] (MSB_FIRST=0) or shreg[MAX_LEN-1] (MSB_FIRST=1).
//    Forced to 0 in IDLE.
//  - Length clamp: len_eff = min(length, MAX_LEN).
//  - IDLE, load=1, len_eff>0:
//    - shreg<=pattern, remaining<=len_eff, next state SHIFT.
//    - First symbol is visible in the cycle after the load edge (latency 1).
//  - IDLE, load=1, len_eff=0:
//    - Stay in IDLE, remaining stays 0.
//    - done=1 for the next cycle (empty letter completes at once).
//  - IDLE, enable=1: ignored. On load+enable in the same cycle, load wins and
//    enable is dropped.
//  - SHIFT, load=1: ignored. No overwrite mid-pattern.
//  - SHIFT, enable=1:
//    - Shift toward the output end with zero fill.
//    - MSB_FIRST=0: shift right. MSB_FIRST=1: shift left.
//    - remaining<=remaining-1.
//    - If remaining was 1: next state IDLE, done=1 for exactly one cycle
//      (the cycle ready returns to 1).
//  - SHIFT, enable=0: hold all state.
//  - done is registered and asserts only on a completion edge. It never stays
//    high two consecutive cycles unless back-to-back completions occur.
//  - A load in the cycle done is high is accepted (back-to-back letters,
//    no dead cycle).
//  - remaining never underflows. It is 0 in IDLE.
//  - reset asserted mid-SHIFT aborts the pattern. No done pulse is generated.
// TESTING
//  - Reset: assert reset mid-pattern -> ready=1, symbol_valid=0, remaining=0,
//    done=0 with no clock edge.
//  - MSB_FIRST=0, load pattern=5'b00110 len=3 ("dot,dash,dash"), enable every
//    4th cycle -> dash_or_dot 0,1,1; remaining 3,2,1; done 1 cycle after 3rd tick.
//  - MSB_FIRST=1, pattern=5'b10000 len=1 -> dash_or_dot=1, remaining=1;
//    one enable -> done pulse, ready=1.
//  - load len=0 -> done high one cycle, symbol_valid stays 0.
//    load len=7 -> clamped to 5 enables before done.
//  - load during SHIFT with a different pattern -> ignored, original sequence intact.
//    load+enable in IDLE -> pattern loaded, remaining=len.
//  - Back-to-back: load a new pattern in the done cycle -> symbol_valid stays 0
//    only on the done cycle edge, next pattern starts with no extra idle cycle.

Source files
------------

// File: rtl/morse_symbol_shifter.sv
// Letter shift register for the Morse transmitter. It takes one variable-length
// dot/dash pattern per load and presents it one symbol at a time to the tone/timing FSM.
module morse_symbol_shifter #(
    parameter int MAX_LEN   = 5,
    parameter int LEN_W     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   length,
    input  logic               enable,
    output logic               ready,
    output logic               dash_or_dot,
    output logic               symbol_valid,
    output logic [LEN_W-1:0]   remaining,
    output logic               done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_t             state;
    logic [MAX_LEN-1:0] shreg;
    logic [LEN_W-1:0]   len_eff;
    logic               out_bit;

    always_comb begin
        len_eff = (length > MAX_LEN_W) ? MAX_LEN_W : length;
    end

    assign out_bit      = (MSB_FIRST != 0) ? shreg[MAX_LEN-1] : shreg[0];
    assign ready        = (state == IDLE);
    assign symbol_valid = (state == SHIFT);
    // Bits that are not part of the pattern can remain in shreg after the last symbol. Gating the output with the state hides them.
    assign dash_or_dot  = (state == SHIFT) & out_bit;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        if (len_eff != '0) begin
                            shreg     <= pattern;
                            remaining <= len_eff;
                            state     <= SHIFT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        shreg     <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
